// File: rtl/piso_pkg.sv
// Shared state encoding and idle line level for the PISO serializer.
// Build option: PISO_PARITY_EN adds a trailing even-parity state.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef PISO_PARITY_EN
      , PAR = 2'd2
`endif
   } state_t;

   localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-side handshake and serial-side outputs of the PISO serializer.
interface piso_serializer_if #(
   parameter int unsigned N = 8
);
   logic         load;
   logic [N-1:0] din;
   logic         ready;
   logic         busy;
   logic         sout;
   logic         done;

   modport master (output load, din, input ready, busy, sout, done);
   modport slave  (input load, din, output ready, busy, sout, done);
endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared on word acceptance, saturates at N so it never wraps.
module piso_bit_counter #(
   parameter int unsigned N = 8
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     clear,
   input  logic                     en,
   output logic [$clog2(N+1)-1:0]   count,
   output logic                     last
);
   localparam int unsigned CW = $clog2(N + 1);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && (count != CW'(N))) begin
         count <= count + CW'(1);
      end
   end

   assign last = (count == CW'(N - 1));
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with load/ready handshake and registered outputs.
// Build option: PISO_PARITY_EN appends one even-parity bit to every frame.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic              clk,
   input logic              clr,
   piso_serializer_if.slave bus
);
   localparam int unsigned CW = $clog2(N + 1);

   state_t        state;
   logic [N-1:0]  shreg;
   logic [CW-1:0] count;
   logic          last;
   logic          accept;
`ifdef PISO_PARITY_EN
   logic          par;
`else
   logic          next_last;
   assign next_last = (count == CW'(N - 2));
`endif

   assign accept = bus.load && bus.ready;

   piso_bit_counter #(
      .N (N)
   ) u_cnt (
      .clk   (clk),
      .clr   (clr),
      .clear (accept),
      .en    (state == SHIFT),
      .count (count),
      .last  (last)
   );

   function automatic logic head(input logic [N-1:0] w);
      return MSB_FIRST ? w[N-1] : w[0];
   endfunction

   function automatic logic [N-1:0] advance(input logic [N-1:0] w);
      return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
   endfunction

   // Acceptance takes priority so a load in the final frame cycle chains with no gap.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         shreg     <= '0;
         bus.sout  <= IDLE_LEVEL;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.ready <= 1'b1;
`ifdef PISO_PARITY_EN
         par       <= 1'b0;
`endif
      end else if (accept) begin
         state     <= SHIFT;
         shreg     <= advance(bus.din);
         bus.sout  <= head(bus.din);
         bus.busy  <= 1'b1;
         bus.done  <= 1'b0;
         bus.ready <= 1'b0;
`ifdef PISO_PARITY_EN
         par       <= ^bus.din;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               state <= IDLE;
            end
            SHIFT: begin
               if (last) begin
`ifdef PISO_PARITY_EN
                  state     <= PAR;
                  bus.sout  <= par;
                  bus.done  <= 1'b1;
                  bus.ready <= 1'b1;
`else
                  state     <= IDLE;
                  bus.sout  <= IDLE_LEVEL;
                  bus.busy  <= 1'b0;
                  bus.done  <= 1'b0;
                  bus.ready <= 1'b1;
`endif
               end else begin
                  shreg     <= advance(shreg);
                  bus.sout  <= head(shreg);
`ifdef PISO_PARITY_EN
                  bus.done  <= 1'b0;
                  bus.ready <= 1'b0;
`else
                  bus.done  <= next_last;
                  bus.ready <= next_last;
`endif
               end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
               state     <= IDLE;
               bus.sout  <= IDLE_LEVEL;
               bus.busy  <= 1'b0;
               bus.done  <= 1'b0;
               bus.ready <= 1'b1;
            end
`endif
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a frame-queue model.
module tb_piso_serializer;
   localparam int unsigned N = 8;
`ifdef PISO_PARITY_EN
   localparam int unsigned PB = 1;
`else
   localparam int unsigned PB = 0;
`endif

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   piso_serializer_if #(.N(N)) bus_m ();
   piso_serializer_if #(.N(N)) bus_l ();

   piso_serializer #(.N(N), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .clr(clr), .bus(bus_m));
   piso_serializer #(.N(N), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .clr(clr), .bus(bus_l));

   int n_chk = 0;
   int n_bad = 0;

   // One entry per upcoming frame cycle: {sout, busy, done}; empty queue means idle.
   logic [2:0]   q_m[$];
   logic [2:0]   q_l[$];
   logic         ld;
   logic [N-1:0] dd;
   logic [15:0]  rx;

   // SIPO receiver on the MSB-first link.
   always @(posedge clk) if (bus_m.busy) rx <= {rx[14:0], bus_m.sout};

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic [2:0] em;
      logic [2:0] el;
      em = (q_m.size() != 0) ? q_m[0] : 3'b000;
      el = (q_l.size() != 0) ? q_l[0] : 3'b000;
      check_eq("m.sout",  16'(bus_m.sout),  16'(em[2]));
      check_eq("m.busy",  16'(bus_m.busy),  16'(em[1]));
      check_eq("m.done",  16'(bus_m.done),  16'(em[0]));
      check_eq("m.ready", 16'(bus_m.ready), 16'(q_m.size() <= 1));
      check_eq("l.sout",  16'(bus_l.sout),  16'(el[2]));
      check_eq("l.busy",  16'(bus_l.busy),  16'(el[1]));
      check_eq("l.done",  16'(bus_l.done),  16'(el[0]));
      check_eq("l.ready", 16'(bus_l.ready), 16'(q_l.size() <= 1));
   endtask

   // Model of one clock edge: retire the current cycle, then append a new frame if accepted.
   task automatic model_edge();
      logic rdy;
      rdy = (q_m.size() <= 1);
      if (q_m.size() != 0) void'(q_m.pop_front());
      if (q_l.size() != 0) void'(q_l.pop_front());
      if (ld && rdy) begin
         for (int i = 0; i < int'(N); i++) begin
            q_m.push_back({dd[N-1-i], 1'b1, (PB == 0) && (i == int'(N) - 1)});
            q_l.push_back({dd[i],     1'b1, (PB == 0) && (i == int'(N) - 1)});
         end
`ifdef PISO_PARITY_EN
         q_m.push_back({^dd, 1'b1, 1'b1});
         q_l.push_back({^dd, 1'b1, 1'b1});
`endif
      end
   endtask

   task automatic cycle(input logic l, input logic [N-1:0] d);
      ld = l;
      dd = d;
      bus_m.load = l;
      bus_m.din  = d;
      bus_l.load = l;
      bus_l.din  = d;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, N'($urandom));
   endtask

   // Asynchronous clear between edges; outputs must drop before any edge arrives.
   task automatic clr_pulse();
      #2 clr = 1'b1;
      #1;
      q_m.delete();
      q_l.delete();
      check_outputs();
      #1 clr = 1'b0;
   endtask

   task automatic frame_and_rx(input logic [N-1:0] w, input string tag);
      logic [N-1:0] got;
      cycle(1'b1, w);
      idle(int'(N) - 1 + int'(PB));
      cycle(1'b0, '0);
      got = rx[PB +: N];
      check_eq(tag, 16'(got), 16'(w));
   endtask

   initial begin
      bus_m.load = 1'b0;
      bus_m.din  = '0;
      bus_l.load = 1'b0;
      bus_l.din  = '0;
      ld = 1'b0;
      dd = '0;
      #1 clr = 1'b1;
      #1 check_outputs();
      #1 clr = 1'b0;
      idle(2);

      frame_and_rx(8'hA5, "sipo.a5");
      frame_and_rx(8'h01, "sipo.01");
      frame_and_rx(8'h07, "sipo.07");

      // Back-to-back: second load lands in the final cycle of the first frame.
      cycle(1'b1, 8'hFF);
      idle(int'(N) - 1 + int'(PB));
      cycle(1'b1, 8'h00);
      idle(int'(N) + int'(PB) + 2);

      // Load attempts while busy are ignored.
      cycle(1'b1, 8'h96);
      for (int i = 0; i < int'(N) - 2; i++) cycle(1'b1, N'($urandom));
      idle(4);

      // Mid-frame clear after bit 3, then a clean frame.
      cycle(1'b1, 8'hC3);
      idle(3);
      clr_pulse();
      idle(2);
      frame_and_rx(8'h3C, "sipo.3c");

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) clr_pulse();
         cycle($urandom_range(0, 3) != 0, N'($urandom));
      end
      idle(int'(N) + 2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
